// File: rtl/ht_cmd_arbiter_if.sv
// Bundle of client command/result channels and the merged pipeline side of the arbiter.
// The slave modport is the arbiter's view; the master modport drives the clients and pipeline.
interface ht_cmd_arbiter_if #(
    parameter int CHANNELS        = 4,
    parameter int KEY_WIDTH       = 32,
    parameter int VALUE_WIDTH     = 31,
    parameter int RES_WIDTH       = 64,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int TAG_WIDTH = $clog2(CHANNELS);
    localparam int CMD_WIDTH = KEY_WIDTH + VALUE_WIDTH + 2;
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    logic [CHANNELS*CMD_WIDTH-1:0] cmd_i;
    logic [CHANNELS-1:0]           cmd_valid_i;
    logic [CHANNELS-1:0]           cmd_ready_o;
    logic [CMD_WIDTH-1:0]          cmd_o;
    logic [TAG_WIDTH-1:0]          cmd_tag_o;
    logic                          cmd_valid_o;
    logic                          cmd_ready_i;
    logic [RES_WIDTH-1:0]          res_i;
    logic [TAG_WIDTH-1:0]          res_tag_i;
    logic                          res_valid_i;
    logic                          res_ready_o;
    logic [RES_WIDTH-1:0]          res_o;
    logic [CHANNELS-1:0]           res_valid_o;
    logic [CHANNELS-1:0]           res_ready_i;
    logic [CHANNELS*CNT_WIDTH-1:0] outstanding_o;
    logic                          idle_o;
    logic                          err_o;

    modport slave (
        input  cmd_i, cmd_valid_i, cmd_ready_i, res_i, res_tag_i, res_valid_i, res_ready_i,
        output cmd_ready_o, cmd_o, cmd_tag_o, cmd_valid_o, res_ready_o, res_o, res_valid_o,
        output outstanding_o, idle_o, err_o
    );

    modport master (
        output cmd_i, cmd_valid_i, cmd_ready_i, res_i, res_tag_i, res_valid_i, res_ready_i,
        input  cmd_ready_o, cmd_o, cmd_tag_o, cmd_valid_o, res_ready_o, res_o, res_valid_o,
        input  outstanding_o, idle_o, err_o
    );
endinterface

// File: rtl/ht_cmd_arbiter.sv
// Round-robin merge of CHANNELS hash-table command streams into one registered output,
// with per-channel in-flight credit counting and tag-based result routing.
module ht_cmd_arbiter #(
    parameter int CHANNELS        = 4,
    parameter int KEY_WIDTH       = 32,
    parameter int VALUE_WIDTH     = 31,
    parameter int RES_WIDTH       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ht_cmd_arbiter_if.slave    bus
);
    localparam int TAG_WIDTH = $clog2(CHANNELS);
    localparam int CMD_WIDTH = KEY_WIDTH + VALUE_WIDTH + 2;
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [TAG_WIDTH-1:0] LAST_CH = TAG_WIDTH'(CHANNELS - 1);

    logic [CMD_WIDTH-1:0] cmd_p1;
    logic [TAG_WIDTH-1:0] tag_p1;
    logic                 vld_p1;
    logic [TAG_WIDTH-1:0] ptr;
    logic [CNT_WIDTH-1:0] cnt [CHANNELS];
    logic                 err;

    logic                          load;
    logic                          gnt_vld;
    logic [TAG_WIDTH-1:0]          gnt_idx;
    logic [CMD_WIDTH-1:0]          gnt_cmd;
    logic [CHANNELS-1:0]           elig;
    logic [CHANNELS-1:0]           cnt_zero;
    logic [CHANNELS-1:0]           gnt_oh;
    logic [CHANNELS-1:0]           res_sel;
    logic                          tag_ok;
    logic                          res_rdy;
    logic                          res_hs;
    logic [CHANNELS*CNT_WIDTH-1:0] outstanding;

    // A result on an empty channel never underflows; a grant and a real result cancel out.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 inc,
        input logic                 dec
    );
        logic dec_eff;
        dec_eff = dec && (cur != '0);
        if (inc && !dec_eff && (cur != MAX_CNT)) return cur + 1'b1;
        if (dec_eff && !inc) return cur - 1'b1;
        return cur;
    endfunction

    // Arbitration: rotate search start to ptr, first eligible channel wins.
    always_comb begin
        int                   sum;
        logic [TAG_WIDTH-1:0] idx;
        load    = !vld_p1 || bus.cmd_ready_i;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = 0;
        idx     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_zero[c] = (cnt[c] == '0);
            elig[c]     = bus.cmd_valid_i[c] && (cnt[c] < MAX_CNT);
        end
        for (int k = 0; k < CHANNELS; k++) begin
            sum = int'(ptr) + k;
            if (sum >= CHANNELS) sum = sum - CHANNELS;
            idx = TAG_WIDTH'(sum);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt_cmd = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            gnt_oh[c] = load && gnt_vld && (gnt_idx == TAG_WIDTH'(c));
            if (gnt_idx == TAG_WIDTH'(c)) gnt_cmd = bus.cmd_i[c*CMD_WIDTH +: CMD_WIDTH];
        end
    end

    // Out-of-range tags select no channel and are swallowed.
    always_comb begin
        res_sel = '0;
        res_rdy = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.res_tag_i == TAG_WIDTH'(c)) begin
                res_sel[c] = 1'b1;
                res_rdy    = bus.res_ready_i[c];
            end
        end
        tag_ok = |res_sel;
        res_hs = bus.res_valid_i && res_rdy && tag_ok;
    end

    always_comb begin
        outstanding = '0;
        for (int c = 0; c < CHANNELS; c++) outstanding[c*CNT_WIDTH +: CNT_WIDTH] = cnt[c];
    end

    // Stage p1: registered command output, credit counters, sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            cmd_p1 <= '0;
            tag_p1 <= '0;
            ptr    <= '0;
            err    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
        end else begin
            if (load) begin
                vld_p1 <= gnt_vld;
                if (gnt_vld) begin
                    cmd_p1 <= gnt_cmd;
                    tag_p1 <= gnt_idx;
                    ptr    <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
                end
            end
            for (int c = 0; c < CHANNELS; c++)
                cnt[c] <= cnt_next(cnt[c], gnt_oh[c], res_hs && res_sel[c]);
            if ((bus.res_valid_i && !tag_ok) || (res_hs && |(res_sel & cnt_zero)))
                err <= 1'b1;
        end
    end

    assign bus.cmd_ready_o   = gnt_oh;
    assign bus.cmd_o         = cmd_p1;
    assign bus.cmd_tag_o     = tag_p1;
    assign bus.cmd_valid_o   = vld_p1;
    assign bus.res_o         = bus.res_i;
    assign bus.res_valid_o   = res_sel & {CHANNELS{bus.res_valid_i}};
    assign bus.res_ready_o   = res_rdy;
    assign bus.outstanding_o = outstanding;
    assign bus.idle_o        = !vld_p1 && (&cnt_zero);
    assign bus.err_o         = err;
endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Bench for ht_cmd_arbiter: table-driven arbitration rows, hand-written corner sequences and
// a randomized run scored against a queue-based model of in-flight commands per channel.
module tb_ht_cmd_arbiter;
    localparam int CH = 4, KW = 32, VW = 31, RW = 64, MAXO = 8;
    localparam int CW = KW + VW + 2, TW = 2, NW = 4;
    localparam int CH3 = 3, MAX3 = 2, NW3 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    ht_cmd_arbiter_if #(.CHANNELS(CH), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .RES_WIDTH(RW),
                        .MAX_OUTSTANDING(MAXO)) bus ();
    ht_cmd_arbiter_if #(.CHANNELS(CH3), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .RES_WIDTH(RW),
                        .MAX_OUTSTANDING(MAX3)) bus3 ();

    ht_cmd_arbiter #(.CHANNELS(CH), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .RES_WIDTH(RW),
                     .MAX_OUTSTANDING(MAXO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    ht_cmd_arbiter #(.CHANNELS(CH3), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .RES_WIDTH(RW),
                     .MAX_OUTSTANDING(MAX3)) dut3 (.clk_i(clk), .rst_i(rst3), .bus(bus3));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: each channel keeps a queue of the commands it has in flight.
    logic [CW-1:0] inflight [CH][$];
    logic [CW-1:0] m_cmd;
    int            m_tag;
    bit            m_vld;
    int            m_ptr;
    bit            m_err;
    logic [CH-1:0] snap_rdy;
    logic [CH-1:0] snap_rv;

    task automatic model_reset();
        m_cmd = '0; m_tag = 0; m_vld = 0; m_ptr = 0; m_err = 0;
        for (int c = 0; c < CH; c++) inflight[c].delete();
    endtask

    function automatic logic [CH*CW-1:0] rand_cmds();
        logic [CH*CW-1:0] v;
        for (int i = 0; i < CH*CW; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic set_idle();
        bus.cmd_i = rand_cmds(); bus.cmd_valid_i = '0; bus.cmd_ready_i = 1'b1;
        bus.res_i = '0; bus.res_tag_i = '0; bus.res_valid_i = 1'b0; bus.res_ready_i = '1;
    endtask

    task automatic check_regs();
        logic [CH*NW-1:0] e_out;
        bit all_empty;
        all_empty = 1;
        for (int c = 0; c < CH; c++) begin
            e_out[c*NW +: NW] = NW'(inflight[c].size());
            if (inflight[c].size() != 0) all_empty = 0;
        end
        chk("cmd_valid_o", 128'(bus.cmd_valid_o), 128'(m_vld));
        chk("cmd_tag_o", 128'(bus.cmd_tag_o), 128'(m_tag));
        chk("cmd_o", 128'(bus.cmd_o), 128'(m_cmd));
        chk("outstanding_o", 128'(bus.outstanding_o), 128'(e_out));
        chk("idle_o", 128'(bus.idle_o), 128'(!m_vld && all_empty));
        chk("err_o", 128'(bus.err_o), 128'(m_err));
    endtask

    // Entered at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic run_cycle();
        bit load;
        int g, t;
        bit e_rr;
        logic [CH-1:0] e_rdy, e_rv;
        load = !m_vld || bus.cmd_ready_i;
        g = -1;
        if (load)
            for (int k = 0; k < CH; k++) begin
                int c = (m_ptr + k) % CH;
                if (g < 0 && bus.cmd_valid_i[c] && inflight[c].size() < MAXO) g = c;
            end
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        t = int'(bus.res_tag_i);
        e_rr = bus.res_ready_i[t];
        e_rv = '0;
        if (bus.res_valid_i) e_rv[t] = 1'b1;
        #1;
        snap_rdy = bus.cmd_ready_o;
        snap_rv  = bus.res_valid_o;
        chk("cmd_ready_o", 128'(bus.cmd_ready_o), 128'(e_rdy));
        chk("res_valid_o", 128'(bus.res_valid_o), 128'(e_rv));
        chk("res_ready_o", 128'(bus.res_ready_o), 128'(e_rr));
        chk("res_o", 128'(bus.res_o), 128'(bus.res_i));
        if (bus.res_valid_i && e_rr) begin
            if (inflight[t].size() == 0) m_err = 1;
            else void'(inflight[t].pop_front());
        end
        if (g >= 0) begin
            logic [CW-1:0] cm;
            cm = bus.cmd_i[g*CW +: CW];
            inflight[g].push_back(cm);
            m_cmd = cm; m_tag = g; m_vld = 1; m_ptr = (g + 1) % CH;
        end else if (load) begin
            m_vld = 0;
        end
        @(posedge clk); #1;
        check_regs();
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst_cmd_valid", 128'(bus.cmd_valid_o), 128'(0));
        chk("rst_cmd_o", 128'(bus.cmd_o), 128'(0));
        chk("rst_cmd_tag", 128'(bus.cmd_tag_o), 128'(0));
        chk("rst_outstanding", 128'(bus.outstanding_o), 128'(0));
        chk("rst_idle", 128'(bus.idle_o), 128'(1));
        chk("rst_err", 128'(bus.err_o), 128'(0));
    endtask

    typedef struct {
        logic [CH-1:0] cv;
        logic          cr;
        logic [CH-1:0] e_rdy;
        logic          e_vld;
        logic [TW-1:0] e_tag;
    } vec_t;

    initial begin
        vec_t tbl [10];
        logic [CW-1:0] held_cmd;
        logic [CH*NW-1:0] held_out;
        int issued;

        bus3.cmd_i = '0; bus3.cmd_valid_i = '0; bus3.cmd_ready_i = 1'b1;
        bus3.res_i = '0; bus3.res_tag_i = '0; bus3.res_valid_i = 1'b0; bus3.res_ready_i = '1;

        tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[5] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[6] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[7] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[9] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.cmd_valid_i = tbl[i].cv;
            bus.cmd_ready_i = tbl[i].cr;
            bus.cmd_i = rand_cmds();
            run_cycle();
            chk($sformatf("tbl%0d_ready", i), 128'(snap_rdy), 128'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 128'(bus.cmd_valid_o), 128'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_tag", i), 128'(bus.cmd_tag_o), 128'(tbl[i].e_tag));
        end

        // Credit limit on a single channel, then one returned credit releases one command.
        do_reset();
        bus.cmd_valid_i = 4'b0100;
        issued = 0;
        for (int i = 0; i < 12; i++) begin
            bus.cmd_i = rand_cmds();
            run_cycle();
            if (snap_rdy[2]) issued++;
        end
        chk("credit_issued", 128'(issued), 128'(8));
        chk("credit_cnt2", 128'(bus.outstanding_o[2*NW +: NW]), 128'(8));
        chk("credit_ready2", 128'(snap_rdy), 128'(0));
        bus.res_valid_i = 1'b1; bus.res_tag_i = 2'd2; bus.res_i = {$urandom, $urandom};
        run_cycle();
        bus.res_valid_i = 1'b0;
        issued = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            if (snap_rdy[2]) issued++;
        end
        chk("credit_reissue", 128'(issued), 128'(1));

        // Backpressure: held command stays put and counters freeze.
        do_reset();
        bus.cmd_valid_i = 4'b1111;
        run_cycle();
        held_cmd = bus.cmd_o;
        held_out = bus.outstanding_o;
        bus.cmd_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_i = rand_cmds();
            run_cycle();
            chk("stall_cmd", 128'(bus.cmd_o), 128'(held_cmd));
            chk("stall_tag", 128'(bus.cmd_tag_o), 128'(0));
            chk("stall_ready", 128'(snap_rdy), 128'(0));
            chk("stall_cnt", 128'(bus.outstanding_o), 128'(held_out));
        end

        // Grant and result on ch1 in the same cycle leave its count unchanged.
        do_reset();
        bus.cmd_valid_i = 4'b0010;
        for (int i = 0; i < 3; i++) run_cycle();
        bus.res_valid_i = 1'b1; bus.res_tag_i = 2'd1; bus.res_ready_i = 4'b1111;
        run_cycle();
        chk("same_cyc_rv", 128'(snap_rv), 128'(4'b0010));
        chk("same_cyc_grant", 128'(snap_rdy), 128'(4'b0010));
        chk("same_cyc_cnt1", 128'(bus.outstanding_o[1*NW +: NW]), 128'(3));
        bus.res_valid_i = 1'b0;

        // Reset mid-operation with busy state; arbitration restarts at ch0.
        bus.cmd_valid_i = 4'b1111;
        for (int i = 0; i < 5; i++) run_cycle();
        bus.cmd_ready_i = 1'b0;
        run_cycle();
        do_reset();
        bus.cmd_valid_i = 4'b1111;
        run_cycle();
        chk("post_rst_grant", 128'(snap_rdy), 128'(4'b0001));

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int t;
            bus.cmd_valid_i = 4'($urandom);
            bus.cmd_ready_i = ($urandom_range(0, 3) != 0);
            bus.cmd_i = rand_cmds();
            bus.res_i = {$urandom, $urandom};
            bus.res_ready_i = 4'($urandom);
            t = $urandom_range(0, CH - 1);
            bus.res_tag_i = 2'(t);
            bus.res_valid_i = (inflight[t].size() > 0) && ($urandom_range(0, 1) == 1);
            run_cycle();
        end

        // Three-channel instance: wrap order, out-of-range tag, result on empty channel.
        @(posedge clk); #1;
        rst3 = 1'b0;
        chk("c3_rst_idle", 128'(bus3.idle_o), 128'(1));
        chk("c3_rst_err", 128'(bus3.err_o), 128'(0));
        bus3.cmd_valid_i = 3'b111;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("c3_tag%0d", i), 128'(bus3.cmd_tag_o), 128'(i % 3));
        end
        bus3.cmd_valid_i = '0;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        bus3.res_valid_i = 1'b1; bus3.res_tag_i = 2'd3; bus3.res_ready_i = 3'b000;
        #1;
        chk("c3_badtag_ready", 128'(bus3.res_ready_o), 128'(1));
        chk("c3_badtag_rv", 128'(bus3.res_valid_o), 128'(0));
        chk("c3_badtag_err_before", 128'(bus3.err_o), 128'(0));
        @(posedge clk); #1;
        bus3.res_valid_i = 1'b0;
        chk("c3_badtag_err", 128'(bus3.err_o), 128'(1));
        chk("c3_badtag_cnt", 128'(bus3.outstanding_o), 128'(0));
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        chk("c3_err_cleared", 128'(bus3.err_o), 128'(0));
        bus3.res_valid_i = 1'b1; bus3.res_tag_i = 2'd0; bus3.res_ready_i = 3'b001;
        #1;
        chk("c3_empty_rv", 128'(bus3.res_valid_o), 128'(3'b001));
        chk("c3_empty_ready", 128'(bus3.res_ready_o), 128'(1));
        @(posedge clk); #1;
        bus3.res_valid_i = 1'b0;
        chk("c3_empty_err", 128'(bus3.err_o), 128'(1));
        chk("c3_empty_cnt", 128'(bus3.outstanding_o[0 +: NW3]), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
